// File: rtl/hit_scan_ctrl.sv
// Sequential bullet-vs-formation collision scanner, one grid cell per clock.
// Define HIT_SCAN_BOTTOM_FIRST_EN to scan rows from the bottom row upward.
module hit_scan_ctrl #(
    parameter int NUM_INVADERS      = 10,
    parameter int NUM_ROWS          = 3,
    parameter int OFFSET            = 100,
    parameter int INVADER_WIDTH     = 64,
    parameter int INVADER_HEIGHT    = 32,
    parameter int PROJECTILE_WIDTH  = 16,
    parameter int PROJECTILE_HEIGHT = 32
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          scan_start,
    input  logic [11:0]                                   projectile_xpos,
    input  logic [11:0]                                   projectile_ypos,
    input  logic [NUM_INVADERS-1:0][11:0]                 invader_x_positions,
    input  logic [9:0]                                    enemy_ypos,
    input  logic                                          bullet_active,
    input  logic                                          wave_reset,
    output logic [NUM_ROWS-1:0][NUM_INVADERS-1:0]         alive,
    output logic [$clog2(NUM_ROWS*NUM_INVADERS+1)-1:0]    alive_count,
    output logic                                          all_dead,
    output logic                                          busy,
    output logic                                          scan_done,
    output logic                                          bullet_hit,
    output logic [$clog2(NUM_ROWS)-1:0]                   hit_row,
    output logic [$clog2(NUM_INVADERS)-1:0]               hit_col
);

    localparam int TOTAL = NUM_ROWS * NUM_INVADERS;
    localparam int CNTW  = $clog2(TOTAL + 1);
    localparam int RW    = $clog2(NUM_ROWS);
    localparam int CW    = $clog2(NUM_INVADERS);

`ifdef HIT_SCAN_BOTTOM_FIRST_EN
    localparam logic [RW-1:0] ROW_FIRST = RW'(NUM_ROWS - 1);
    localparam logic [RW-1:0] ROW_LAST  = '0;
`else
    localparam logic [RW-1:0] ROW_FIRST = '0;
    localparam logic [RW-1:0] ROW_LAST  = RW'(NUM_ROWS - 1);
`endif
    localparam logic [CW-1:0] COL_LAST  = CW'(NUM_INVADERS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t state;
    state_t state_d;

    logic [RW-1:0]                row;
    logic [CW-1:0]                col;
    logic [RW-1:0]                row_step;
    logic [11:0]                  px_q;
    logic [11:0]                  py_q;
    logic [NUM_INVADERS-1:0][11:0] xs_q;
    logic [9:0]                   ey_q;

    logic [12:0] px13;
    logic [12:0] py13;
    logic [12:0] xc13;
    logic [12:0] yr13;
    logic        x_ov;
    logic        y_ov;
    logic        cell_hit;
    logic        last_col;
    logic        last_cell;

    logic take;
    logic step;
    logic busy_d;
    logic done_d;
    logic hit_d;

    // Shared overlap comparator, driven by the snapshot and the cell index.
    always_comb begin
        px13 = {1'b0, px_q};
        py13 = {1'b0, py_q};
        xc13 = {1'b0, xs_q[col]};
        yr13 = 13'(ey_q) + 13'(row) * 13'(OFFSET);
        x_ov = (px13 < xc13 + 13'(INVADER_WIDTH)) &&
               (px13 + 13'(PROJECTILE_WIDTH) > xc13);
        y_ov = (py13 <= yr13 + 13'(INVADER_HEIGHT)) &&
               (py13 + 13'(PROJECTILE_HEIGHT) >= yr13);
        cell_hit  = x_ov && y_ov && alive[row][col];
        last_col  = (col == COL_LAST);
        last_cell = last_col && (row == ROW_LAST);
`ifdef HIT_SCAN_BOTTOM_FIRST_EN
        row_step  = row - 1'b1;
`else
        row_step  = row + 1'b1;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (scan_start && bullet_active) state_d = SCAN;
            SCAN:    if (!bullet_active || cell_hit || last_cell) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (wave_reset) state_d = IDLE;
    end

    always_comb begin
        take   = (state == IDLE) && scan_start && bullet_active && !wave_reset;
        step   = (state == SCAN) && bullet_active && !wave_reset;
        busy_d = (state_d != IDLE);
        done_d = (state == SCAN) && (state_d == DONE);
        hit_d  = done_d && step && cell_hit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy       <= 1'b0;
            scan_done  <= 1'b0;
            bullet_hit <= 1'b0;
        end else begin
            busy       <= busy_d;
            scan_done  <= done_d;
            bullet_hit <= hit_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alive       <= '1;
            alive_count <= CNTW'(TOTAL);
            all_dead    <= 1'b0;
            hit_row     <= '0;
            hit_col     <= '0;
            row         <= '0;
            col         <= '0;
            px_q        <= '0;
            py_q        <= '0;
            xs_q        <= '0;
            ey_q        <= '0;
        end else if (wave_reset) begin
            alive       <= '1;
            alive_count <= CNTW'(TOTAL);
            all_dead    <= 1'b0;
        end else begin
            if (take) begin
                px_q <= projectile_xpos;
                py_q <= projectile_ypos;
                xs_q <= invader_x_positions;
                ey_q <= enemy_ypos;
                row  <= ROW_FIRST;
                col  <= '0;
            end
            if (step) begin
                if (cell_hit) begin
                    alive[row][col] <= 1'b0;
                    alive_count     <= alive_count - CNTW'(1);
                    all_dead        <= (alive_count == CNTW'(1));
                    hit_row         <= row;
                    hit_col         <= col;
                end else if (last_col) begin
                    // Row index stays in range after the final cell.
                    col <= '0;
                    if (!last_cell) row <= row_step;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hit_scan_ctrl.sv
// Randomized self-checking bench for hit_scan_ctrl against a scan-order model.
// Honors HIT_SCAN_BOTTOM_FIRST_EN the same way as the design.
module tb_hit_scan_ctrl;

    localparam int N = 10;
    localparam int R = 3;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 scan_start = 1'b0;
    logic [11:0]          projectile_xpos = '0;
    logic [11:0]          projectile_ypos = '0;
    logic [N-1:0][11:0]   invader_x_positions;
    logic [9:0]           enemy_ypos = 10'd50;
    logic                 bullet_active = 1'b1;
    logic                 wave_reset = 1'b0;
    logic [R-1:0][N-1:0]  alive;
    logic [4:0]           alive_count;
    logic                 all_dead;
    logic                 busy;
    logic                 scan_done;
    logic                 bullet_hit;
    logic [1:0]           hit_row;
    logic [3:0]           hit_col;

    int checks = 0;
    int errors = 0;

    logic [R-1:0][N-1:0] am;
    int m_count;
    int mh_row;
    int mh_col;

    hit_scan_ctrl dut (
        .clk                 (clk),
        .rst                 (rst),
        .scan_start          (scan_start),
        .projectile_xpos     (projectile_xpos),
        .projectile_ypos     (projectile_ypos),
        .invader_x_positions (invader_x_positions),
        .enemy_ypos          (enemy_ypos),
        .bullet_active       (bullet_active),
        .wave_reset          (wave_reset),
        .alive               (alive),
        .alive_count         (alive_count),
        .all_dead            (all_dead),
        .busy                (busy),
        .scan_done           (scan_done),
        .bullet_hit          (bullet_hit),
        .hit_row             (hit_row),
        .hit_col             (hit_col)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic int xpos(input int c);
        return 80 * c;
    endfunction

    // First live overlapping cell in scan order, or -1.
    function automatic int find_hit(input int px, input int py,
                                    output int hr, output int hc);
        hr = 0;
        hc = 0;
        for (int p = 0; p < R; p++) begin
            int r;
`ifdef HIT_SCAN_BOTTOM_FIRST_EN
            r = R - 1 - p;
`else
            r = p;
`endif
            for (int c = 0; c < N; c++) begin
                int yr;
                bit xo;
                bit yo;
                yr = 50 + 100 * r;
                xo = (px < xpos(c) + 64) && (px + 16 > xpos(c));
                yo = (py <= yr + 32) && (py + 32 >= yr);
                if (am[r][c] && xo && yo) begin
                    hr = r;
                    hc = c;
                    return p * N + c;
                end
            end
        end
        return -1;
    endfunction

    task automatic model_reset();
        am = '1;
        m_count = R * N;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_alive"}, 64'(alive), 64'(am));
        check({tag, "_count"}, 64'(alive_count), 64'(m_count));
        check({tag, "_dead"}, 64'(all_dead), 64'(m_count == 0));
        check({tag, "_row"}, 64'(hit_row), 64'(mh_row));
        check({tag, "_col"}, 64'(hit_col), 64'(mh_col));
    endtask

    task automatic run_scan(input string tag, input int px, input int py,
                            input int abort_at, input bit poke);
        int k;
        int hr;
        int hc;
        int exp_n;
        bit exp_hit;
        int n;
        bit done;
        k = find_hit(px, py, hr, hc);
        if (abort_at >= 0 && (k < 0 || k >= abort_at)) begin
            exp_hit = 0;
            exp_n = abort_at + 1;
        end else if (k >= 0) begin
            exp_hit = 1;
            exp_n = k + 1;
        end else begin
            exp_hit = 0;
            exp_n = R * N;
        end
        @(negedge clk);
        projectile_xpos = 12'(px);
        projectile_ypos = 12'(py);
        bullet_active = 1'b1;
        scan_start = 1'b1;
        @(posedge clk);
        #1;
        scan_start = 1'b0;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        n = 0;
        done = 0;
        while (!done && n < 40) begin
            if (abort_at >= 0 && n == abort_at) bullet_active = 1'b0;
            if (n == 1) begin
                projectile_xpos = 12'($urandom_range(0, 900));
                projectile_ypos = 12'($urandom_range(0, 400));
            end
            if (poke && exp_n >= 6 && n == 3) scan_start = 1'b1;
            if (n == 4) scan_start = 1'b0;
            @(posedge clk);
            n++;
            #1;
            if (scan_done) done = 1;
        end
        scan_start = 1'b0;
        check({tag, "_lat"}, 64'(n), 64'(exp_n));
        check({tag, "_hit"}, 64'(bullet_hit), 64'(exp_hit));
        if (exp_hit) begin
            am[hr][hc] = 1'b0;
            m_count--;
            mh_row = hr;
            mh_col = hc;
        end
        check_state(tag);
        @(posedge clk);
        #1;
        check({tag, "_idle"}, 64'({busy, scan_done, bullet_hit}), 64'd0);
        bullet_active = 1'b1;
    endtask

    task automatic pulse_wave();
        @(negedge clk);
        wave_reset = 1'b1;
        @(negedge clk);
        wave_reset = 1'b0;
        model_reset();
        check("wave_alive", 64'(alive), 64'(am));
    endtask

    initial begin
        int dn;
        for (int j = 0; j < N; j++) invader_x_positions[j] = 12'(80 * j);
        model_reset();
        mh_row = 0;
        mh_col = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_state("reset");
        check("reset_out", 64'({busy, scan_done, bullet_hit}), 64'd0);

        run_scan("mid", 84, 160, -1, 1'b0);
        check("mid_cell", 64'(alive[1][1]), 64'd0);
        run_scan("dead", 84, 160, -1, 1'b0);
        pulse_wave();
        run_scan("ybound", 84, 82, -1, 1'b0);
        pulse_wave();
        run_scan("xmiss", 64, 60, -1, 1'b0);
        run_scan("xhit", 65, 60, -1, 1'b0);
        run_scan("busy_start", 500, 320, -1, 1'b1);
        run_scan("abort", 500, 320, 5, 1'b0);

        @(negedge clk);
        bullet_active = 1'b0;
        scan_start = 1'b1;
        @(negedge clk);
        scan_start = 1'b0;
        check("ignored_start", 64'(busy), 64'd0);
        bullet_active = 1'b1;

        for (int i = 0; i < 50; i++) begin
            int ab;
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 29)) : -1;
            run_scan("rand", int'($urandom_range(0, 800)),
                     int'($urandom_range(0, 330)), ab, $urandom_range(0, 1) == 1);
        end

        @(negedge clk);
        projectile_xpos = 12'd500;
        projectile_ypos = 12'd320;
        scan_start = 1'b1;
        @(posedge clk);
        #1;
        scan_start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        wave_reset = 1'b1;
        @(posedge clk);
        #1;
        wave_reset = 1'b0;
        model_reset();
        check("wmid_busy", 64'(busy), 64'd0);
        check("wmid_alive", 64'(alive), 64'(am));
        check("wmid_count", 64'(alive_count), 64'(m_count));
        dn = 0;
        repeat (35) begin
            @(posedge clk);
            #1;
            if (scan_done) dn++;
        end
        check("wmid_nodone", 64'(dn), 64'd0);

        for (int r = 0; r < R; r++)
            for (int c = 0; c < N; c++)
                if (am[r][c]) run_scan("kill", 80 * c + 24, 50 + 100 * r, -1, 1'b0);
        check("all_dead", 64'(all_dead), 64'd1);
        run_scan("empty", 84, 160, -1, 1'b0);

        @(negedge clk);
        scan_start = 1'b1;
        @(posedge clk);
        #1;
        scan_start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        mh_row = 0;
        mh_col = 0;
        check_state("rst_mid");
        check("rst_mid_out", 64'({busy, scan_done, bullet_hit}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_scan("post_rst", 84, 160, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hit_scan_ctrl.md
# hit_scan_ctrl

Sequential collision scheduler for the invader formation. It replaces a fully parallel bullet-vs-grid compare with one shared overlap comparator, time-multiplexed over every grid cell at one cell per clock. It owns the alive mask, and kills at most one invader per scan. It sits between the player-bullet logic, which issues one scan request per frame, and the invader renderer and score logic, which consume `alive`, `bullet_hit`, `hit_row` and `hit_col`.

## Interface
- NUM_INVADERS, 10, columns per row
- NUM_ROWS, 3, rows in formation
- OFFSET, 100, vertical pixel pitch between rows
- INVADER_WIDTH, 64, invader box width (px)
- INVADER_HEIGHT, 32, invader box height (px)
- PROJECTILE_WIDTH, 16, bullet box width (px)
- PROJECTILE_HEIGHT, 32, bullet box height (px)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- scan_start  in  1  scan request pulse
- projectile_xpos  in  12  bullet left edge
- projectile_ypos  in  12  bullet top edge
- invader_x_positions  in  [NUM_INVADERS][12]  column left edges
- enemy_ypos  in  10  top edge of row 0
- bullet_active  in  1  bullet in flight
- wave_reset  in  1  synchronous pulse; revive the whole formation
- alive  out  [NUM_ROWS][NUM_INVADERS]  1 = invader alive
- alive_count  out  $clog2(NUM_ROWS*NUM_INVADERS+1)  number of live invaders
- all_dead  out  1  alive_count == 0
- busy  out  1  scan in progress
- scan_done  out  1  one-cycle pulse at end of scan
- bullet_hit  out  1  one-cycle pulse, qualified by scan_done
- hit_row  out  $clog2(NUM_ROWS)  row of the killed invader
- hit_col  out  $clog2(NUM_INVADERS)  column of the killed invader

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE → SCAN:
  - Transition when `scan_start && bullet_active`.
  - Snapshot the projectile position, all x positions and `enemy_ypos`.
  - Load the cell index with the first cell.
- `scan_start` is ignored in IDLE when `bullet_active = 0`, and ignored in any state other than IDLE.
- SCAN: each cycle evaluates one cell (r, c) against the snapshot.
  - y_r = enemy_ypos + r*OFFSET.
  - x_ov = (px < x_c + INVADER_WIDTH) && (px + PROJECTILE_WIDTH > x_c). Both bounds are strict.
  - y_ov = (py <= y_r + INVADER_HEIGHT) && (py + PROJECTILE_HEIGHT >= y_r). Both bounds are inclusive.
  - All sums are computed in 13 bits. Nothing wraps or truncates.
- On a hit (`x_ov && y_ov && alive[r][c]`):
  - Clear `alive[r][c]` and decrement `alive_count` on the same edge.
  - Latch `hit_row` and `hit_col`, set the hit flag, go to DONE.
- Otherwise advance the column. On the last column, wrap to column 0 of the next row. After the last cell, go to DONE with no hit.
- Dead cells are skipped: they never hit, but they still consume their cycle.
- `bullet_active` falling during SCAN aborts the scan. The FSM goes to DONE with no hit.
- DONE lasts one cycle:
  - `scan_done = 1`; `bullet_hit` = hit flag.
  - Then return to IDLE.
- `wave_reset` has highest priority in every state:
  - Set `alive` to all ones and `alive_count` to NUM_ROWS*NUM_INVADERS.
  - Force IDLE, clear pulses and the hit flag.
  - An in-flight scan gives no `scan_done`.
- `hit_row` and `hit_col` hold their value until the next hit.

## Timing
- Reset values:
  - `alive` = all ones; `alive_count` = NUM_ROWS*NUM_INVADERS.
  - `all_dead` = 0, `busy` = 0, `scan_done` = 0, `bullet_hit` = 0.
  - `hit_row` = 0, `hit_col` = 0; FSM = IDLE.
- Reset asserted mid-scan returns every output to its reset value immediately.
- All outputs are registered.
- The start is sampled at edge E. Let k be the cell's position in scan order.
  - Cell k is evaluated in the cycle after edge E+k.
  - Hit at k: `scan_done`, `bullet_hit` and the `alive` update appear at edge E+k+1.
  - Full miss: `scan_done` appears at edge E+R*N.
  - Abort detected in cycle k: `scan_done` appears at edge E+k+1.
- `busy` is high from edge E through the DONE cycle inclusive.
- The next start is accepted in the cycle after DONE.
- Worst case is R*N+2 cycles per scan (32 with defaults), far below one frame.

## Configuration
- Macro `HIT_SCAN_BOTTOM_FIRST_EN`:
  - Defined: rows are scanned from NUM_ROWS-1 down to 0. The lowest overlapping invader, nearest the rising bullet, is the one killed.
  - Undefined: rows are scanned from 0 upward.
- Columns are always scanned from 0 upward.
- k = (scan-order row position)*NUM_INVADERS + c.

## Test plan
Test setup: defaults; invader_x_positions[j] = 80*j; enemy_ypos = 50; bullet_active = 1.
- Hit mid-grid: start with (px, py) = (84, 160).
  - Kill at row 1, col 1 (k = 11 in both orders).
  - `scan_done` and `bullet_hit` at E+12; `alive[1][1]` = 0; `alive_count` = 29.
- Repeat the same start: the cell is dead, so the scan misses. `scan_done` at E+30, `bullet_hit` = 0, `alive_count` stays 29.
- Inclusive y boundary: (84, 82) hits row 0, col 1.
  - Without macro: done at E+2.
  - With macro: done at E+22.
- Strict x boundary: px = 64, py = 60 (k = 0 misses); px = 65 hits row 0, col 1.
- Control events:
  - `scan_start` while busy: no effect.
  - `bullet_active` dropped at E+5: `scan_done` at E+6, no hit.
  - `wave_reset` at E+3: no `scan_done`; `alive` = all ones.
- Exhaustion:
  - Kill all 30 invaders: `all_dead` = 1 when `alive_count` = 0.
  - Async `rst` mid-scan: all outputs return to reset values immediately.
